i2s_dac_tx: RTL and testbench

Serialises the 24-bit signed output sample stream of the tulip DSP chain into a standard Philips I2S frame for the codec DAC. It sits directly downstream of the output gain stage and consumes its `dout`/`dout_valid`/`dout_ready` stream. It generates BCLK and LRCLK from the system clock and sends each mono sample in both the left and right slots. It provides one sample of buffering, mutes on underflow, and counts underflow events.

---
 rtl/tulip_dsp_pkg.sv | 16 +
 rtl/i2s_clock_gen.sv | 51 +++++
 rtl/i2s_dac_tx.sv | 105 ++++++++++
 tb/tb_i2s_dac_tx.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tulip_dsp_pkg.sv
// Shared types and constants for the tulip DSP chain.
// Sample format and I2S slot geometry used by the output stages.
package tulip_dsp_pkg;

  localparam int C_ADC_DWIDTH    = 24;
  localparam int C_I2S_SLOT_BITS = 32;

  typedef logic signed [C_ADC_DWIDTH-1:0] sample_t;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// BCLK divider and bit-period counter for the I2S transmitter.
// Period b starts on a bclk fall; lrclk follows b.
module i2s_clock_gen
  import tulip_dsp_pkg::*;
#(
  parameter int G_SLOT_BITS = C_I2S_SLOT_BITS,
  parameter int G_BCLK_DIV  = 4,
  localparam int BW = $clog2(2*G_SLOT_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          bclk,
  output logic          lrclk,
  output logic          period_start,
  output logic [BW-1:0] b
);

  localparam int CW = (G_BCLK_DIV > 1) ? $clog2(G_BCLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(G_BCLK_DIV-1);
  localparam logic [BW-1:0] B_LAST = BW'(2*G_SLOT_BITS-1);
  localparam logic [BW-1:0] B_SLOT = BW'(G_SLOT_BITS);

  logic [CW-1:0] div_cnt;
  logic          half;
  logic          run;

  assign run = enable & ~reset;

  // Half-period divider; b advances when bclk falls
  always_ff @(posedge clk) begin
    if (!run) begin
      div_cnt <= '0;
      half    <= 1'b0;
      b       <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      half    <= ~half;
      if (half) begin
        b <= (b == B_LAST) ? '0 : b + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign bclk = half;
  assign lrclk = (b >= B_SLOT);
  assign period_start = run & ~half & (div_cnt == '0);

endmodule

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter for the DAC: mono sample in both slots,
// one-deep holding register, muting and counting on underflow.
module i2s_dac_tx
  import tulip_dsp_pkg::*;
#(
  parameter int G_DWIDTH    = C_ADC_DWIDTH,
  parameter int G_SLOT_BITS = C_I2S_SLOT_BITS,
  parameter int G_BCLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                frame_strobe,
  output logic [15:0]         underflow_count
);

  localparam int BW = $clog2(2*G_SLOT_BITS);
  localparam logic [BW-1:0] B_LAST = BW'(2*G_SLOT_BITS-1);
  localparam logic [BW-1:0] B_SLOT = BW'(G_SLOT_BITS);
  localparam logic [BW-1:0] B_DW   = BW'(G_DWIDTH);

  logic                period_start;
  logic [BW-1:0]       b;
  logic [G_DWIDTH-1:0] hold;
  logic [G_DWIDTH-1:0] shadow;
  logic                hold_full;
  logic                primed;
  logic                xfer;
  logic                load;
  logic [BW-1:0]       bm1;
  logic [BW-1:0]       pos;
  logic [G_DWIDTH-1:0] shifted;

  i2s_clock_gen #(
    .G_SLOT_BITS (G_SLOT_BITS),
    .G_BCLK_DIV  (G_BCLK_DIV)
  ) u_clk (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bclk         (i2s_bclk),
    .lrclk        (i2s_lrclk),
    .period_start (period_start),
    .b            (b)
  );

  assign din_ready = enable & ~reset & ~hold_full;
  assign xfer = din_valid & din_ready;
  assign load = period_start & (b == '0);
  assign frame_strobe = load;

  // Holding/shadow registers: shadow only changes at a frame load
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hold      <= '0;
      shadow    <= '0;
      hold_full <= 1'b0;
      primed    <= 1'b0;
    end else begin
      if (xfer) begin
        primed <= 1'b1;
      end
      if (load) begin
        if (hold_full) begin
          shadow    <= hold;
          hold_full <= 1'b0;
        end else if (xfer) begin
          shadow <= din;
        end else begin
          shadow <= '0;
        end
      end else if (xfer) begin
        hold      <= din;
        hold_full <= 1'b1;
      end
    end
  end

  // Count muted frames once a sample has been seen; survives disable
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_count <= '0;
    end else if (load && !hold_full && !xfer && primed) begin
      underflow_count <= sat_inc16(underflow_count);
    end
  end

  // Data mux: slot position (b-1) mod slot, MSB first, zero padded
  always_comb begin
    bm1 = (b == '0) ? B_LAST : b - 1'b1;
    pos = (bm1 >= B_SLOT) ? bm1 - B_SLOT : bm1;
    shifted = shadow << pos;
    i2s_sdata = 1'b0;
    if (pos < B_DW) begin
      i2s_sdata = shifted[G_DWIDTH-1];
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx with a sample scoreboard
// and an I2S frame deserialiser.
module tb_i2s_dac_tx;
  import tulip_dsp_pkg::*;

  localparam int DIV   = 2;
  localparam int SLOT  = 32;
  localparam int DW    = 24;
  localparam int FRAME = 4*SLOT*DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  sample_t     din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        frame_strobe;
  logic [15:0] underflow_count;

  i2s_dac_tx #(
    .G_DWIDTH    (DW),
    .G_SLOT_BITS (SLOT),
    .G_BCLK_DIV  (DIV)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .din             (din),
    .din_valid       (din_valid),
    .din_ready       (din_ready),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .frame_strobe    (frame_strobe),
    .underflow_count (underflow_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail = 0;
  sample_t     sb_q[$];
  logic        primed_m = 1'b0;
  logic [15:0] uf_m = '0;
  logic [DW-1:0] cur_exp = '0;
  logic        in_frame = 1'b0;
  int          k = 0;
  logic [63:0] cap_d = '0;
  logic [63:0] cap_l = '0;
  logic        prev_bclk = 1'b0;
  int          frames_done = 0;

  function automatic logic [63:0] exp_data(input logic [DW-1:0] w);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < DW; i++) begin
      v[1+i] = w[DW-1-i];
      v[SLOT+1+i] = w[DW-1-i];
    end
    return v;
  endfunction

  // Scoreboard model plus frame capture on each bclk rise
  always @(negedge clk) begin
    if (reset || !enable) begin
      sb_q.delete();
      primed_m = 1'b0;
      in_frame = 1'b0;
      if (reset) uf_m = '0;
    end else begin
      if (din_valid && din_ready) begin
        sb_q.push_back(din);
        primed_m = 1'b1;
      end
      if (frame_strobe) begin
        if (in_frame) begin
          n_tests++;
          if (k !== 64) begin
            n_fail++;
            $display("FAIL frame_len: got %0d bits want 64", k);
          end
        end
        if (sb_q.size() > 0) begin
          cur_exp = sb_q.pop_front();
        end else begin
          cur_exp = '0;
          if (primed_m && uf_m != 16'hFFFF) uf_m++;
        end
        in_frame = 1'b1;
        k = 0;
        cap_d = '0;
        cap_l = '0;
      end
      if (in_frame && i2s_bclk && !prev_bclk && k < 64) begin
        cap_d[k] = i2s_sdata;
        cap_l[k] = i2s_lrclk;
        k++;
        if (k == 64) begin
          n_tests++;
          if (cap_d !== exp_data(cur_exp)) begin
            n_fail++;
            $display("FAIL frame_data: got %h want %h (sample %h)",
                     cap_d, exp_data(cur_exp), cur_exp);
          end
          n_tests++;
          if (cap_l !== 64'hFFFFFFFF_00000000) begin
            n_fail++;
            $display("FAIL frame_lrclk: got %h want %h",
                     cap_l, 64'hFFFFFFFF_00000000);
          end
          n_tests++;
          if (underflow_count !== uf_m) begin
            n_fail++;
            $display("FAIL frame_uf: got %h want %h",
                     underflow_count, uf_m);
          end
          frames_done++;
        end
      end
    end
    prev_bclk = i2s_bclk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reset = 1'b1;
    enable = 1'b0;
    din_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    enable = 1'b1;
  endtask

  task automatic wait_frames_to(input int target);
    int budget;
    budget = 8*FRAME;
    while (frames_done < target && budget > 0) begin
      tick();
      budget--;
    end
    if (frames_done < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_wait: got %0d frames want %0d",
               frames_done, target);
    end
  endtask

  task automatic offer(input sample_t s);
    bit ok;
    din = s;
    din_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 3*FRAME && !ok; n++) begin
      @(negedge clk);
      if (din_ready) ok = 1'b1;
      tick();
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept: got no transfer want sample %h", s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b0;
    din_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      n_tests++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe} !== 5'b0
          || underflow_count !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_out: got %b/%h want 0/0",
                 {i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe},
                 underflow_count);
      end
    end
    tick();
    reset = 1'b0;
    din_valid = 1'b1;
    repeat (300) begin
      @(negedge clk);
      n_tests++;
      if ({i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe} !== 5'b0
          || underflow_count !== 16'h0) begin
        n_fail++;
        $display("FAIL idle_out: got %b/%h want 0/0",
                 {i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe},
                 underflow_count);
      end
    end
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_pre_prime();
    int base;
    restart();
    base = frames_done;
    @(negedge clk);
    n_tests++;
    if ({frame_strobe, i2s_bclk, i2s_lrclk} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_c0: got %b want 100",
               {frame_strobe, i2s_bclk, i2s_lrclk});
    end
    @(negedge clk);
    n_tests++;
    if (i2s_bclk !== 1'b0) begin
      n_fail++;
      $display("FAIL start_c1_bclk: got %b want 0", i2s_bclk);
    end
    @(negedge clk);
    n_tests++;
    if (i2s_bclk !== 1'b1) begin
      n_fail++;
      $display("FAIL start_c2_bclk: got %b want 1", i2s_bclk);
    end
    wait_frames_to(base + 5);
    n_tests++;
    if (underflow_count !== 16'h0) begin
      n_fail++;
      $display("FAIL preprime_uf: got %h want 0000", underflow_count);
    end
  endtask

  task automatic test_single();
    int base;
    restart();
    base = frames_done;
    repeat (10) tick();
    offer(24'h800001);
    din_valid = 1'b0;
    n_tests++;
    if (din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0", din_ready);
    end
    wait_frames_to(base + 3);
    n_tests++;
    if (underflow_count !== 16'h1) begin
      n_fail++;
      $display("FAIL single_uf: got %h want 0001", underflow_count);
    end
  endtask

  task automatic test_stream();
    int base;
    sample_t s[3];
    s[0] = 24'h000001;
    s[1] = 24'h7FFFFF;
    s[2] = 24'hABCDEF;
    restart();
    base = frames_done;
    for (int i = 0; i < 3; i++) begin
      offer(s[i]);
      if (i > 0) begin
        n_tests++;
        if (din_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_ready%0d: got %b want 0", i, din_ready);
        end
      end
    end
    din_valid = 1'b0;
    wait_frames_to(base + 3);
    n_tests++;
    if (underflow_count !== 16'h0) begin
      n_fail++;
      $display("FAIL stream_uf: got %h want 0000", underflow_count);
    end
  endtask

  task automatic test_bypass();
    int base;
    restart();
    base = frames_done;
    repeat (256) tick();
    din = 24'h123456;
    din_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({frame_strobe, din_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL bypass_load: got %b want 11",
               {frame_strobe, din_ready});
    end
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_hold: got ready %b want 1", din_ready);
    end
    wait_frames_to(base + 2);
    n_tests++;
    if (underflow_count !== 16'h0) begin
      n_fail++;
      $display("FAIL bypass_uf: got %h want 0000", underflow_count);
    end
  endtask

  task automatic test_disable_sat();
    int base;
    restart();
    repeat (160) tick();
    enable = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({i2s_lrclk, frame_strobe, din_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL drop_b40: got %b want 100",
               {i2s_lrclk, frame_strobe, din_ready});
    end
    tick();
    n_tests++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe} !== 5'b0
        || underflow_count !== 16'h0) begin
      n_fail++;
      $display("FAIL drop_out: got %b/%h want 0/0",
               {i2s_bclk, i2s_lrclk, i2s_sdata, din_ready, frame_strobe},
               underflow_count);
    end
    repeat (5) tick();
    force dut.underflow_count = 16'hFFFF;
    tick();
    release dut.underflow_count;
    uf_m = 16'hFFFF;
    tick();
    n_tests++;
    if (underflow_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_preset: got %h want FFFF", underflow_count);
    end
    enable = 1'b1;
    base = frames_done;
    @(negedge clk);
    n_tests++;
    if ({frame_strobe, i2s_bclk, i2s_lrclk} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart_b0: got %b want 100",
               {frame_strobe, i2s_bclk, i2s_lrclk});
    end
    tick();
    offer(24'h654321);
    din_valid = 1'b0;
    wait_frames_to(base + 3);
    n_tests++;
    if (underflow_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_uf: got %h want FFFF", underflow_count);
    end
  endtask

  initial begin
    test_reset();
    test_pre_prime();
    test_single();
    test_stream();
    test_bypass();
    test_disable_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
